// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared constants for the UART receive buffer. Defines the
//             default data width and the layout of one buffered entry,
//             {stop_error, p_error, data}.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Default received byte width
    localparam int UART_DATA_W  = 8;

    // Entry layout at the default width
    localparam int ENT_DATA_LSB = 0;
    localparam int ENT_PERR_BIT = UART_DATA_W;
    localparam int ENT_SERR_BIT = UART_DATA_W + 1;
    localparam int ENT_W        = UART_DATA_W + 2;

    // Field positions for an arbitrary data width
    function automatic int ent_perr_bit(input int dw);
        return dw;
    endfunction

    function automatic int ent_serr_bit(input int dw);
        return dw + 1;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo_mem
//  Purpose  : Simple dual-port register array (DEPTH x WIDTH) with a
//             synchronous write port and a registered read port. The read
//             register holds its value until the next read enable.
//  Ports    : clk, rst (async, active-high, clears only the read register)
//             i_we / i_waddr / i_wdata   write port
//             i_re / i_raddr / o_rdata   registered read port
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Storage contents are intentionally not reset
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-before-write: a read and write to the same address in one cycle
    // returns the old contents, which is what the full-buffer pass-through
    // case relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : uart_rx_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_buffer
//  Purpose  : Receive-side circular FIFO behind a UART receiver. Captures
//             each frame {stop_error, p_error, data} on wr_valid, hands them
//             to the consumer via rd_en / rd_valid (1-cycle latency), and
//             raises a sticky overrun when a frame is lost to a full buffer.
//  Ports    : clk, reset (async active-high)
//             wr_valid, wr_data, wr_p_error, wr_stop_error   receiver side
//             rd_en, rd_data, rd_p_error, rd_stop_error, rd_valid  host side
//             empty, full, almost_full, count                status
//             overrun, overrun_clr                           overrun flag
//             err_drop (only with UART_RX_ERR_DROP_EN)
//  Config   : `define UART_RX_ERR_DROP_EN to discard frames carrying a
//             parity or stop error instead of storing them.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W   = UART_DATA_W,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_p_error,
    input  logic                       wr_stop_error,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_p_error,
    output logic                       rd_stop_error,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun,
    input  logic                       overrun_clr
`ifdef UART_RX_ERR_DROP_EN
    ,
    output logic                       err_drop
`endif
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_W   = AW + 1;
    localparam int EW      = DATA_W + 2;
    localparam int PERR_B  = ent_perr_bit(DATA_W);
    localparam int SERR_B  = ent_serr_bit(DATA_W);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_almost_full;
    logic             r_overrun;
    logic             r_rd_valid;

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_wr_frame;   // wr_valid for a frame eligible for storage
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [EW-1:0]    w_wr_entry;
    logic [EW-1:0]    w_rd_entry;

`ifdef UART_RX_ERR_DROP_EN
    logic             w_err_frame;
    logic             r_err_drop;

    assign w_err_frame = wr_valid && (wr_p_error || wr_stop_error);
    assign w_wr_frame  = wr_valid && !w_err_frame;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_drop <= 1'b0;
        end else begin
            r_err_drop <= w_err_frame;
        end
    end

    assign err_drop = r_err_drop;
`else
    assign w_wr_frame  = wr_valid;
`endif

    assign w_rd_acc   = rd_en && !r_empty;
    // A full buffer can still take a frame when a read frees a slot this cycle
    assign w_wr_acc   = w_wr_frame && (!r_full || w_rd_acc);
    assign w_wr_entry = {wr_stop_error, wr_p_error, wr_data};

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_count + C_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_cnt_nxt = r_count - C_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overrun     <= 1'b0;
            r_rd_valid    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count       <= w_cnt_nxt;
            r_empty       <= (w_cnt_nxt == '0);
            r_full        <= (w_cnt_nxt == C_DEPTH);
            r_almost_full <= (w_cnt_nxt >= C_AF);
            r_rd_valid    <= w_rd_acc;
            // Set takes priority over clear
            if (w_wr_frame && r_full && !rd_en) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    uart_rx_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    assign rd_data       = w_rd_entry[DATA_W-1:0];
    assign rd_p_error    = w_rd_entry[PERR_B];
    assign rd_stop_error = w_rd_entry[SERR_B];
    assign rd_valid      = r_rd_valid;
    assign empty         = r_empty;
    assign full          = r_full;
    assign almost_full   = r_almost_full;
    assign count         = r_count;
    assign overrun       = r_overrun;

endmodule : uart_rx_buffer
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_buffer
//  Purpose  : Self-checking bench for uart_rx_buffer (DEPTH=16, DATA_W=8).
//             A queue-based reference model predicts every output each cycle;
//             directed sequences add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_p_error = 1'b0;
    logic          wr_stop_error = 1'b0;
    logic          rd_en = 1'b0;
    logic          overrun_clr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_p_error;
    logic          rd_stop_error;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [4:0]    count;
    logic          overrun;
`ifdef UART_RX_ERR_DROP_EN
    logic          err_drop;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_p_error    (wr_p_error),
        .wr_stop_error (wr_stop_error),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_p_error    (rd_p_error),
        .rd_stop_error (rd_stop_error),
        .rd_valid      (rd_valid),
        .empty         (empty),
        .full          (full),
        .almost_full   (almost_full),
        .count         (count),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
`ifdef UART_RX_ERR_DROP_EN
        ,
        .err_drop      (err_drop)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [9:0]    mq[$];
    logic [DW-1:0] m_rd_data;
    logic          m_rd_pe, m_rd_se, m_rd_valid, m_overrun, m_err_drop;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_rd_data = '0; m_rd_pe = 1'b0; m_rd_se = 1'b0;
            m_rd_valid = 1'b0; m_overrun = 1'b0; m_err_drop = 1'b0;
        end else begin
            bit frame, bad, racc, wacc;
            logic [9:0] e;
            int sz;
            sz = mq.size();
            bad = wr_p_error || wr_stop_error;
`ifdef UART_RX_ERR_DROP_EN
            frame = wr_valid && !bad;
            m_err_drop = wr_valid && bad;
`else
            frame = wr_valid;
            m_err_drop = 1'b0;
`endif
            racc = rd_en && (sz > 0);
            wacc = frame && ((sz < DEPTH) || racc);
            m_rd_valid = racc;
            if (racc) begin
                e = mq.pop_front();
                m_rd_data = e[7:0]; m_rd_pe = e[8]; m_rd_se = e[9];
            end
            if (wacc) mq.push_back({wr_stop_error, wr_p_error, wr_data});
            if (frame && sz == DEPTH && !rd_en) m_overrun = 1'b1;
            else if (overrun_clr) m_overrun = 1'b0;
        end
        #1;
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFL));
        chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        chk("rd_data", 32'(rd_data), 32'(m_rd_data));
        chk("rd_p_error", 32'(rd_p_error), 32'(m_rd_pe));
        chk("rd_stop_error", 32'(rd_stop_error), 32'(m_rd_se));
        chk("overrun", 32'(overrun), 32'(m_overrun));
`ifdef UART_RX_ERR_DROP_EN
        chk("err_drop", 32'(err_drop), 32'(m_err_drop));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] b, input logic pe, input logic se);
        wr_valid = 1'b1; wr_data = b; wr_p_error = pe; wr_stop_error = se;
        tick();
        wr_valid = 1'b0; wr_p_error = 1'b0; wr_stop_error = 1'b0;
    endtask

    task automatic rd_expect(input string name, input logic [7:0] b);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk({name, "_data"}, 32'(rd_data), 32'(b));
    endtask

    initial begin
        tick(); tick();
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_count", 32'(count), 32'd0);
        reset = 1'b0;

        // Basic ordering
        wr(8'h41, 0, 0); wr(8'h42, 0, 0); wr(8'h43, 0, 0);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_empty", 32'(empty), 32'd0);
        rd_expect("t1_r0", 8'h41);
        rd_expect("t1_r1", 8'h42);
        rd_expect("t1_r2", 8'h43);
        chk("t1_empty_end", 32'(empty), 32'd1);

        // Fill, thresholds, overrun
        for (int i = 0; i < 16; i++) begin
            wr(8'(i), 0, 0);
            if (i == 10) chk("t2_af_11", 32'(almost_full), 32'd0);
            if (i == 11) chk("t2_af_12", 32'(almost_full), 32'd1);
            if (i == 14) chk("t2_full_15", 32'(full), 32'd0);
        end
        chk("t2_full", 32'(full), 32'd1);
        wr(8'h99, 0, 0);
        chk("t2_overrun", 32'(overrun), 32'd1);
        chk("t2_count16", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) rd_expect("t2_rd", 8'(i));
        chk("t2_overrun_hold", 32'(overrun), 32'd1);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        chk("t2_overrun_clr", 32'(overrun), 32'd0);

        // Full with simultaneous write and read
        for (int i = 0; i < 16; i++) wr(8'(i), 0, 0);
        wr_valid = 1'b1; wr_data = 8'hAA; rd_en = 1'b1;
        tick();
        wr_valid = 1'b0; rd_en = 1'b0;
        chk("t3_rd_data", 32'(rd_data), 32'h00);
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_overrun", 32'(overrun), 32'd0);
        for (int i = 1; i < 16; i++) rd_expect("t3_rd", 8'(i));
        rd_expect("t3_last", 8'hAA);

        // Empty with simultaneous write and read
        wr_valid = 1'b1; wr_data = 8'h55; rd_en = 1'b1;
        tick();
        wr_valid = 1'b0; rd_en = 1'b0;
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_rd_valid", 32'(rd_valid), 32'd0);
        rd_expect("t4_rd", 8'h55);

        // Errored frames
        wr(8'h7E, 1, 0);
`ifdef UART_RX_ERR_DROP_EN
        chk("t5_drop0", 32'(err_drop), 32'd1);
`endif
        wr(8'h7F, 0, 1);
`ifdef UART_RX_ERR_DROP_EN
        chk("t5_drop1", 32'(err_drop), 32'd1);
        chk("t5_count", 32'(count), 32'd0);
`else
        chk("t5_count", 32'(count), 32'd2);
        rd_expect("t5_r0", 8'h7E);
        chk("t5_pe", 32'(rd_p_error), 32'd1);
        chk("t5_se0", 32'(rd_stop_error), 32'd0);
        rd_expect("t5_r1", 8'h7F);
        chk("t5_pe1", 32'(rd_p_error), 32'd0);
        chk("t5_se", 32'(rd_stop_error), 32'd1);
`endif

        // Reset mid-stream
        for (int i = 0; i < 5; i++) wr(8'(8'h60 + i), 0, 0);
        rd_expect("t6_r0", 8'h60);
        rd_expect("t6_r1", 8'h61);
        rd_en = 1'b1; reset = 1'b1;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_data", 32'(rd_data), 32'd0);
        chk("t6_rst_valid", 32'(rd_valid), 32'd0);
        tick();
        reset = 1'b0; rd_en = 1'b0;
        tick();
        chk("t6_no_valid", 32'(rd_valid), 32'd0);
        wr(8'h11, 0, 0);
        rd_expect("t6_after", 8'h11);

        // Pointer wrap-around
        for (int i = 0; i < 40; i++) begin
            wr(8'(8'h80 + i), 0, 0);
            rd_expect("t7_wrap", 8'(8'h80 + i));
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx_buffer
`default_nettype wire
